// File: rtl/nibble_serial_adder_if.sv
// Start/operand/result bundle between a controller (master) and nibble_serial_adder (slave).
// Master drives start, a, b, cin; slave returns busy, done, sum, cout, ovf.
// Carries no logic; the adder registers every output it drives onto this bundle.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder reusing one 4-bit carry-lookahead slice, least-significant nibble first.
// Latency: WIDTH/4 edges from the accept edge to a one-cycle done pulse; period WIDTH/4+1.
// Backpressure: start is only taken in IDLE or DONE; start during RUN is ignored.
//
// Ports: clk, rst_n (async active-low); bus (slave modport): start, a, b, cin in;
//        busy, done, sum, cout, ovf out, all registered.
// Optional feature: define NIBBLE_SERIAL_OVF_EN to build the signed-overflow flag;
// without it ovf is tied to 0.
module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int N   = WIDTH / 4;
  localparam int K_W = (N > 1) ? $clog2(N) : 1;

  if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [K_W-1:0]   r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_p;
  logic [3:0]       w_g;
  logic [4:0]       w_c;
  logic [3:0]       w_sum_nib;
  logic             w_last;

  // Current nibble of each held operand; {k,00} is the nibble's bit offset.
  assign w_a_nib = r_a[{r_k, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_k, 2'b00} +: 4];

  // 4-bit carry-lookahead slice fed by the held inter-nibble carry.
  assign w_p    = w_a_nib ^ w_b_nib;
  assign w_g    = w_a_nib & w_b_nib;
  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_sum_nib = w_p ^ w_c[3:0];

  assign w_last = (r_k == K_W'(N - 1));

`ifdef NIBBLE_SERIAL_OVF_EN
  logic r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          // Nibbles above k keep their old contents until their own edge.
          r_sum[{r_k, 2'b00} +: 4] <= w_sum_nib;
          r_carry                  <= w_c[4];
          r_k                      <= r_k + K_W'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cout  <= w_c[4];
`ifdef NIBBLE_SERIAL_OVF_EN
            // w_c[3] is the carry into the MSB of the final nibble.
            r_ovf   <= w_c[3] ^ w_c[4];
`endif
          end
        end
        default: begin
          // IDLE and DONE accept a new operation identically.
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_k     <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
`ifdef NIBBLE_SERIAL_OVF_EN
  assign bus.ovf  = r_ovf;
`else
  assign bus.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder (WIDTH=32) against an
// arithmetic reference: {cout,sum} = a + b + cin, ovf from operand/result signs.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nibble_serial_adder;

  localparam int W = 32;
`ifdef NIBBLE_SERIAL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result of one add.
  task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    co   = full[W];
    ov   = OVF_EN && (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  // One isolated add. Optionally drives start with zero operands into the
  // edge after T3 (i.e. at T4) to show it is ignored.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input bit inject);
    logic [W-1:0] es;
    logic         eco, eov;
    int           edges;
    bit           busy_ok;
    ref_add(a, b, c, es, eco, eov);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = c;
    @(posedge clk);                       // accept edge T0
    @(negedge clk);
    edges   = 0;
    busy_ok = 1'b1;
    while (!bus.done && edges < 20) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (inject && edges == 3) begin
        bus.start = 1'b1; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      end else begin
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom);
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, ".latency"}, 64'(edges), 64'd8);
    check({tag, ".busy_run"}, 64'(busy_ok), 64'd1);
    check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, ".sum"}, 64'(bus.sum), 64'(es));
    check({tag, ".cout"}, 64'(bus.cout), 64'(eco));
    check({tag, ".ovf"}, 64'(bus.ovf), 64'(eov));
    @(negedge clk);
    check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, ".sum_hold"}, 64'(bus.sum), 64'(es));
  endtask

  // Continuous start: every done cycle re-accepts the next operand set.
  task automatic back_to_back(input int n_ops);
    logic [W-1:0] qa[$], qb[$];
    logic         qc[$];
    logic [W-1:0] es, ea, eb;
    logic         eco, eov, ec;
    int           ndone, last;
    ndone = 0;
    last  = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom);
    qa.push_back(bus.a); qb.push_back(bus.b); qc.push_back(bus.cin);
    for (int cyc = 0; cyc < 12 * n_ops && ndone < n_ops; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
        ref_add(ea, eb, ec, es, eco, eov);
        check("b2b.sum", 64'(bus.sum), 64'(es));
        check("b2b.cout", 64'(bus.cout), 64'(eco));
        check("b2b.ovf", 64'(bus.ovf), 64'(eov));
        if (last >= 0) check("b2b.period", 64'(cyc - last), 64'd9);
        last = cyc;
        ndone++;
        if (ndone < n_ops) begin
          bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom);
          qa.push_back(bus.a); qb.push_back(bus.b); qc.push_back(bus.cin);
        end else begin
          bus.start = 1'b0;
        end
      end else begin
        if (!bus.busy) check("b2b.busy", 64'(bus.busy), 64'd1);
        bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    check("b2b.count", 64'(ndone), 64'(n_ops));
  endtask

  initial begin
    int dones;
    n_cmp = 0;
    n_mis = 0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.sum", 64'(bus.sum), 64'd0);
    check("rst.cout", 64'(bus.cout), 64'd0);
    check("rst.ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    run_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op("start_in_run", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++)
      run_op("rand", $urandom, $urandom, 1'($urandom), 1'($urandom_range(0, 1)));

    back_to_back(6);
    repeat (12) @(negedge clk);

    // Reset in the middle of an add (after T3), with a nonzero prior sum.
    run_op("pre_rst", 32'h0F0F_0F0F, 32'h1111_1111, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst.busy", 64'(bus.busy), 64'd0);
    check("midrst.done", 64'(bus.done), 64'd0);
    check("midrst.sum", 64'(bus.sum), 64'd0);
    check("midrst.cout", 64'(bus.cout), 64'd0);
    check("midrst.ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("midrst.no_done", 64'(dones), 64'd0);

    run_op("post_rst", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Area-reduced WIDTH-bit adder that reuses a single 4-bit carry-lookahead slice over WIDTH/4 clock cycles, least-significant nibble first, with the carry held in a register between nibbles. It sits upstream of the 4-bit CLA slice. It latches the operands, steps the slice through them, and assembles the full-width sum. Its start/busy/done handshake lets a controller trade latency for area against the fully parallel 32-bit CLA.

## Interface
- WIDTH, 32, operand/sum width; must be a multiple of 4 and at least 8; N = WIDTH/4 nibbles
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low
- start  in  1  request; accepted only in IDLE or DONE
- a  in  WIDTH  operand A; sampled on the accept edge only
- b  in  WIDTH  operand B; sampled on the accept edge only
- cin  in  1  carry-in; sampled on the accept edge only
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse: result valid
- sum  out  WIDTH  registered result
- cout  out  1  registered carry-out of bit WIDTH-1
- ovf  out  1  signed overflow (see Configuration)

## Operation
- States:
  - IDLE: start=1 → RUN; capture a, b, cin; nibble index k=0.
  - RUN: each edge adds nibble k of a_reg and b_reg with carry_reg via the 4-bit CLA.
    - Write the 4-bit result into sum[4k+3:4k]; carry_reg ← slice carry-out; k++.
    - Edge with k=N-1 → DONE; cout ← final carry.
  - DONE: done=1 for this cycle only.
    - start=1 → RUN with a new capture (same semantics as IDLE).
    - else → IDLE.
- start in RUN is ignored. Operands are not re-sampled and the result is unaffected.
- Each nibble add is the standard CLA: p=a^b, g=a&b, lookahead carries, sum nibble = p^c.
- Sum nibbles not yet written hold their previous values. sum is defined only from done onward.
- sum, cout and ovf hold their values through IDLE until the next accepted start.
- k is a log2(N)-bit counter; no wrap-around occurs because RUN exits at k=N-1.
- Asynchronous reset, any state including mid-RUN:
  - State → IDLE; k=0; carry_reg=0; operand registers cleared.
  - Outputs busy=0, done=0, sum=0, cout=0, ovf=0.
  - An operation in flight is discarded; no done follows reset release.

## Timing
- Accept edge T0 (start=1, state IDLE or DONE).
- Nibble edges are T1..TN. busy=1 for cycles T0..T(N-1) (after each edge) and falls after TN.
- done=1 in the cycle after TN, together with valid sum, cout and ovf. Latency is N edges from accept to done; N=8 for WIDTH=32.
- Back-to-back: holding start=1 during the DONE cycle re-accepts immediately. Period is N+1 cycles.
- busy and done are never high together.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro NIBBLE_SERIAL_OVF_EN.
- Defined:
  - ovf ← carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, registered at TN.
  - ovf is valid with done and held until the next accept.
  - The carry into bit WIDTH-1 is taken from inside the final nibble's lookahead.
- Undefined: ovf is tied to 0 and no overflow logic is built.

## Test plan
- Reset mid-operation, WIDTH=32: assert rst_n=0 at T3 of an add. busy=0, done=0, sum=0, cout=0 immediately. After release with start=0, no done pulse for 20 cycles.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0. done after T8; sum=0x00000000, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0. sum=0x80000000, cout=0. ovf=1 with NIBBLE_SERIAL_OVF_EN, ovf=0 without.
- Mixed nibbles with carry-in: a=0x12345678, b=0x9ABCDEF0, cin=1. sum=0xACF13569, cout=0, done exactly 8 edges after accept.
- Start during RUN: at T4 drive start=1 with a=0, b=0. This is ignored and busy stays high. The result matches the original operands and exactly one done pulse occurs.
- Back-to-back: hold start=1 continuously with new operands each accept. done pulses every 9 cycles and each sum matches its own captured operands.
